// File: rtl/si5341_cfg_pkg.sv
// Shared definitions for the Si5341A configuration sequencer: FSM state codes,
// register-table entry layout and the byte-ordering helper for I2C writes.
package si5341_cfg_pkg;

  typedef logic [3:0] state_t;

  localparam state_t IDLE    = 4'd0;
  localparam state_t FETCH   = 4'd1;
  localparam state_t DECODE  = 4'd2;
  localparam state_t PAGE_TX = 4'd3;
  localparam state_t REG_TX  = 4'd4;
  localparam state_t GAP     = 4'd5;
  localparam state_t DELAY   = 4'd6;
  localparam state_t NEXT    = 4'd7;
  localparam state_t DONE    = 4'd8;

  localparam logic [7:0] PAGE_REG   = 8'h01;
  localparam logic [7:0] DELAY_MARK = 8'hFF;

  localparam int PAGE_HI = 23;
  localparam int PAGE_LO = 16;
  localparam int REG_HI  = 15;
  localparam int REG_LO  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef struct packed {
    logic [7:0] page;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } entry_t;

  // A page-select write is {dev, 0x01, page}; a register write is {dev, reg, data}.
  function automatic logic [7:0] tx_byte(input logic is_page, input logic [1:0] pos,
                                         input entry_t e, input logic [7:0] dev);
    logic [7:0] b;
    case (pos)
      2'd0:    b = dev;
      2'd1:    b = is_page ? PAGE_REG : e.reg_addr;
      default: b = is_page ? e.page : e.data;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/si5341_cfg_seq_if.sv
// Byte-write handshake between the configuration sequencer and i2c_ctrl.
interface si5341_cfg_seq_if;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       wr_done;
  logic       rd_req;

  modport master (output wr_req, output wr_data, output rd_req, input wr_done);
  modport slave  (input wr_req, input wr_data, input rd_req, output wr_done);
endinterface

// File: rtl/si5341_cfg_rom.sv
// Synchronous one-cycle register table exported from ClockBuilder; addresses past
// the last real entry read back as zero-length delay markers so they are harmless.
module si5341_cfg_rom
  import si5341_cfg_pkg::*;
#(
  parameter int TABLE_LEN = 16,
  parameter int AW        = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [23:0]   data
);

  function automatic logic [23:0] rom_entry(input int i);
    logic [23:0] e;
    case (i)
      0:       e = 24'h0B24C0;
      1:       e = 24'h0B2500;
      2:       e = 24'h050201;
      3:       e = 24'h054001;
      4:       e = 24'hFF012C;
      5:       e = 24'h000601;
      6:       e = 24'h000B74;
      7:       e = 24'h01020A;
      8:       e = 24'h022503;
      9:       e = 24'h001C01;
      10:      e = 24'h0B24C3;
      11:      e = 24'h0B2502;
      default: e = {DELAY_MARK, 16'h0000};
    endcase
    return e;
  endfunction

  always_ff @(posedge clk) begin
    data <= rom_entry(int'(addr));
  end

endmodule

// File: rtl/si5341_cfg_seq.sv
// Walks the Si5341A register table and feeds i2c_ctrl one 3-byte write at a time,
// inserting page-select writes on page changes and honouring delay markers.
module si5341_cfg_seq
  import si5341_cfg_pkg::*;
#(
  parameter int         SYS_CLK    = 50_000_000,
  parameter logic [7:0] DEV_ADDR   = 8'hE8,
  parameter int         TABLE_LEN  = 16,
  parameter int         AW         = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1,
  parameter int         GAP_CYCLES = 250,
  parameter int         DELAY_UNIT = SYS_CLK / 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [AW-1:0]          tbl_addr,
  input  logic [23:0]            tbl_data,
  si5341_cfg_seq_if.master       i2c,
  output logic                   busy,
  output logic                   cfg_done
);

  localparam int DW = 16 + $clog2(DELAY_UNIT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DU_W     = DW'(DELAY_UNIT);
  localparam logic [DW-1:0] DLY_TAIL = DW'(3);
  localparam logic [AW-1:0] LAST_IDX = AW'(TABLE_LEN - 1);

  state_t          state;
  logic [AW-1:0]   idx;
  entry_t          entry;
  logic [7:0]      cur_page;
  logic            page_valid;
  logic [1:0]      byte_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [DW-1:0]   dly_cnt;
  logic [DW-1:0]   dly_load;
  logic            gap_to_reg;
  logic            armed;
  logic            start_ok;

  assign i2c.rd_req = 1'b0;
  assign dly_load   = DW'(tbl_data[REG_HI:DATA_LO]) * DU_W;
  assign start_ok   = start && armed;

  // armed stays low for the first edge after reset so a start coincident with release is dropped.
  // The delay countdown stops at 3 because fetch, decode and next already account for three cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      tbl_addr    <= '0;
      entry       <= '0;
      cur_page    <= 8'h00;
      page_valid  <= 1'b0;
      byte_cnt    <= 2'd0;
      gap_cnt     <= '0;
      dly_cnt     <= '0;
      gap_to_reg  <= 1'b0;
      armed       <= 1'b0;
      i2c.wr_req  <= 1'b0;
      i2c.wr_data <= 8'h00;
      busy        <= 1'b0;
      cfg_done    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state      <= FETCH;
            idx        <= '0;
            tbl_addr   <= '0;
            busy       <= 1'b1;
            cfg_done   <= 1'b0;
            page_valid <= 1'b0;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          entry <= tbl_data;
          if (tbl_data[PAGE_HI:PAGE_LO] == DELAY_MARK) begin
            dly_cnt <= dly_load;
            state   <= (dly_load == '0) ? NEXT : DELAY;
          end else begin
            state       <= (!page_valid || tbl_data[PAGE_HI:PAGE_LO] != cur_page) ? PAGE_TX : REG_TX;
            i2c.wr_req  <= 1'b1;
            i2c.wr_data <= DEV_ADDR;
            byte_cnt    <= 2'd0;
          end
        end
        PAGE_TX, REG_TX: begin
          if (i2c.wr_done) begin
            if (byte_cnt == 2'd2) begin
              i2c.wr_req <= 1'b0;
              state      <= GAP;
              gap_cnt    <= GW'(GAP_CYCLES - 1);
              gap_to_reg <= (state == PAGE_TX);
              if (state == PAGE_TX) begin
                cur_page   <= entry.page;
                page_valid <= 1'b1;
              end
            end else begin
              byte_cnt    <= byte_cnt + 2'd1;
              i2c.wr_data <= tx_byte(state == PAGE_TX, byte_cnt + 2'd1, entry, DEV_ADDR);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (gap_to_reg) begin
              state       <= REG_TX;
              gap_to_reg  <= 1'b0;
              i2c.wr_req  <= 1'b1;
              i2c.wr_data <= DEV_ADDR;
              byte_cnt    <= 2'd0;
            end else begin
              state <= NEXT;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DELAY: begin
          if (dly_cnt <= DLY_TAIL) begin
            state <= NEXT;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            state    <= DONE;
            busy     <= 1'b0;
            cfg_done <= 1'b1;
          end else begin
            idx      <= idx + 1'b1;
            tbl_addr <= idx + 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_si5341_cfg_seq.sv
// Scoreboard bench: a table-level reference model queues the expected I2C writes,
// an i2c_ctrl model acknowledges bytes and a monitor compares each completed write.
module tb_si5341_cfg_seq;
  import si5341_cfg_pkg::*;

  localparam int LEN = 8;
  localparam int AWT = 3;
  localparam int GAP = 250;
  localparam int DU  = 100;

  typedef struct {
    logic [23:0] bytes;
    int          gap_mode;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [AWT-1:0] tbl_addr;
  logic [23:0]    tbl_data = 24'h0;
  logic           busy;
  logic           cfg_done;

  logic [23:0] mem [LEN];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          rd_bad = 0;
  int          busy_len;

  si5341_cfg_seq_if i2c();

  si5341_cfg_seq #(
    .SYS_CLK(100_000), .DEV_ADDR(8'hE8), .TABLE_LEN(LEN), .AW(AWT),
    .GAP_CYCLES(GAP), .DELAY_UNIT(DU)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c(i2c.master), .busy(busy), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One-cycle synchronous table read.
  initial begin
    logic [AWT-1:0] a;
    forever begin
      @(negedge clk);
      a = tbl_addr;
      @(posedge clk);
      #1;
      tbl_data = mem[a];
    end
  end

  // i2c_ctrl stand-in: acks each byte after a random latency, with stray pulses while idle.
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = 5;
    i2c.wr_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        i2c.wr_done = 1'b0;
        cnt = 0;
      end else if (i2c.wr_done) begin
        i2c.wr_done = 1'b0;
        cnt = 0;
        lat = $urandom_range(1, 12);
      end else if (i2c.wr_req) begin
        cnt++;
        if (cnt >= lat) i2c.wr_done = 1'b1;
      end else begin
        i2c.wr_done = ($urandom_range(0, 40) == 0);
      end
    end
  end

  // Monitor: assembles 3-byte writes and scores them against the expected queue.
  initial begin
    int          nb;
    int          low_cnt;
    int          gap_seen;
    bit          prev_req;
    logic [23:0] got;
    exp_t        e;
    nb = 0; low_cnt = 0; gap_seen = 0; prev_req = 0; got = '0;
    forever begin
      @(negedge clk);
      if (i2c.rd_req !== 1'b0) rd_bad = 1;
      if (!rst_n) begin
        nb = 0;
        low_cnt = 0;
        prev_req = 0;
      end else begin
        if (i2c.wr_req && !prev_req) begin
          gap_seen = low_cnt;
          low_cnt = 0;
        end else if (!i2c.wr_req) begin
          low_cnt++;
        end
        if (i2c.wr_done && i2c.wr_req) begin
          got = {got[15:0], i2c.wr_data};
          nb++;
          if (nb == 3) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL unexpected_tx: got %h want none", got);
            end else begin
              e = exp_q.pop_front();
              check_output("tx_bytes", 32'(got), 32'(e.bytes));
              if (e.gap_mode == 1) begin
                check_output("gap_exact", gap_seen, GAP);
              end else if (e.gap_mode == 2) begin
                total++;
                if (gap_seen < GAP) begin
                  bad++;
                  $display("[TB] FAIL gap_min: got %0d want >= %0d", gap_seen, GAP);
                end
              end
            end
          end
        end
        prev_req = i2c.wr_req;
      end
    end
  end

  property wr_data_stable;
    @(posedge clk) disable iff (!rst_n)
      (i2c.wr_req && $past(i2c.wr_req) && !$past(i2c.wr_done)) |-> (i2c.wr_data == $past(i2c.wr_data));
  endproperty
  assert property (wr_data_stable)
    else begin
      bad++;
      $display("[TB] FAIL wr_data_stable: got %h want %h", i2c.wr_data, $past(i2c.wr_data));
    end

  // Reference model: page writes on first entry or page change, delay markers produce no I2C.
  task automatic build_expect(output int n_tx, output int delay_sum);
    bit         pv;
    bit         first;
    logic [7:0] cp;
    logic [7:0] p;
    pv = 0; first = 1; cp = 8'h00; n_tx = 0; delay_sum = 0;
    for (int i = 0; i < LEN; i++) begin
      p = mem[i][23:16];
      if (p == 8'hFF) begin
        delay_sum += int'(mem[i][15:0]) * DU;
      end else begin
        if (!pv || p != cp) begin
          exp_q.push_back('{{8'hE8, 8'h01, p}, first ? 0 : 2});
          exp_q.push_back('{{8'hE8, mem[i][15:0]}, 1});
          n_tx += 2;
          pv = 1;
          cp = p;
        end else begin
          exp_q.push_back('{{8'hE8, mem[i][15:0]}, first ? 0 : 2});
          n_tx += 1;
        end
        first = 0;
      end
    end
  endtask

  task automatic fill_markers();
    for (int i = 0; i < LEN; i++) mem[i] = 24'hFF0000;
  endtask

  task automatic random_table();
    logic [7:0] pages [4];
    pages = '{8'h00, 8'h00, 8'h01, 8'h05};
    for (int i = 0; i < LEN; i++) begin
      if ($urandom_range(0, 9) == 0)
        mem[i] = {8'hFF, 8'h00, 8'($urandom_range(0, 2))};
      else
        mem[i] = {pages[$urandom_range(0, 3)], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input string name, input bit poke_busy, output int busy_cnt);
    int n_tx;
    int dsum;
    int cyc;
    build_expect(n_tx, dsum);
    pulse_start();
    check_output({name, "_busy_on"}, busy, 1'b1);
    check_output({name, "_done_clr"}, cfg_done, 1'b0);
    busy_cnt = 0;
    cyc = 0;
    while (!cfg_done && cyc < 60000) begin
      if (busy) busy_cnt++;
      if (poke_busy && cyc == 300) start = 1'b1;
      if (poke_busy && cyc == 301) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_output({name, "_cfg_done"}, cfg_done, 1'b1);
    check_output({name, "_busy_off"}, busy, 1'b0);
    repeat (5) @(negedge clk);
    check_output({name, "_leftover"}, exp_q.size(), 0);
    if (n_tx == 0) begin
      total++;
      if (busy_cnt < dsum + 2 * LEN || busy_cnt > dsum + 4 * LEN + 2) begin
        bad++;
        $display("[TB] FAIL %s_busy_len: got %0d want %0d..%0d", name, busy_cnt,
                 dsum + 2 * LEN, dsum + 4 * LEN + 2);
      end
    end
  endtask

  initial begin
    int n;
    int cyc;
    fill_markers();
    repeat (3) @(negedge clk);
    check_output("rst_tbl_addr", tbl_addr, 0);
    check_output("rst_wr_req", i2c.wr_req, 0);
    check_output("rst_wr_data", i2c.wr_data, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_cfg_done", cfg_done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    fill_markers();
    mem[0] = 24'h000B24;
    apply_stimulus("basic", 0, busy_len);

    fill_markers();
    mem[0] = 24'h000B24; mem[1] = 24'h000C01; mem[2] = 24'h05070A;
    apply_stimulus("pages", 0, busy_len);

    fill_markers();
    mem[0] = 24'hFF0003;
    apply_stimulus("delay", 0, busy_len);

    fill_markers();
    apply_stimulus("zero_delay", 0, busy_len);

    // Reset after the second byte of the first write, then replay from entry 0.
    fill_markers();
    mem[0] = 24'h000B24;
    build_expect(n, cyc);
    pulse_start();
    n = 0;
    cyc = 0;
    while (n < 2 && cyc < 5000) begin
      @(posedge clk);
      #3;
      if (i2c.wr_done && i2c.wr_req) n++;
      cyc++;
    end
    check_output("reset_wait", n, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("reset_wr_req", i2c.wr_req, 0);
    check_output("reset_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_output("start_at_release", busy, 0);
    apply_stimulus("replay", 0, busy_len);

    random_table();
    apply_stimulus("start_busy", 1, busy_len);
    check_output("done_before_rerun", cfg_done, 1);
    apply_stimulus("rerun", 0, busy_len);

    for (int r = 0; r < 4; r++) begin
      random_table();
      apply_stimulus("random", 0, busy_len);
    end

    check_output("rd_req_zero", rd_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
